led_sweep_checker: RTL and testbench
====================================

// Module: led_sweep_checker
// PURPOSE
//   Receive-side checker for the 8-LED bounce ("knight rider") display pattern.
//   Samples an 8-bit LED bus and recovers the sweep position (index 1..14).
//   Locks onto a valid sweep, flags departures from the sequence, and counts completed sweeps.
//   Used in self-test of the LED pattern generator and on boards that loop the LED bus back.
// PARAMETERS
//   LOCK_COUNT  14  consecutive matching samples, first 0x01 included, needed to enter LOCKED; range 1..255
//   ERR_W       8   width of the saturating error counter
//   CNT_W       16  width of the wrapping sweep counter
// PORTS
//   i_clk          in   1      system clock; all logic on posedge
//   i_reset        in   1      synchronous, active-high reset
//   i_valid        in   1      i_led is sampled only on cycles where this is 1
//   i_led          in   8      LED bus under test
//   o_locked       out  1      1 while state is LOCKED
//   o_index        out  4      index of the last matched sample (1..14); 0 in HUNT
//   o_dir          out  1      0 if o_index is 1..8 (rising), 1 if 9..14 (falling)
//   o_error        out  1      one-cycle pulse on a mismatch while LOCKED
//   o_sweep        out  1      one-cycle pulse when LOCKED sees index 14 followed by index 1
//   o_err_count    out  ERR_W  count of o_error pulses; saturates at all-ones
//   o_sweep_count  out  CNT_W  count of o_sweep pulses; wraps to 0
// BEHAVIOUR
//   Expected pattern per index:
//     1..8  -> 8'h01 << (idx-1)
//     9..14 -> 8'h80 >> (idx-8), i.e. 40,20,10,08,04,02
//   Next expected index: idx+1; 14 wraps to 1.
//   All outputs are registered and update on the clock edge after the sampling edge (latency 1).
//   i_valid=0: state, counters, o_index and o_locked hold; o_error=0, o_sweep=0.
//   Reset: state=HUNT, all outputs 0, match count 0. Reset overrides every other event, including mid-sweep.
//   States:
//   HUNT:
//     - valid sample 8'h01 -> o_index=1, match count=1.
//       - LOCK_COUNT==1: go to LOCKED.
//       - otherwise: go to SYNC.
//     - any other valid sample, including 8'h00 -> stay in HUNT, o_index=0, no error.
//   SYNC:
//     - sample == pattern(next index) -> advance o_index and increment match count.
//       - count reaches LOCK_COUNT: go to LOCKED.
//     - mismatch, including zero or multi-hot patterns:
//       - sample is 8'h01: restart SYNC with o_index=1, count=1.
//       - otherwise: go to HUNT with o_index=0.
//       - o_error is not asserted.
//   LOCKED:
//     - match -> advance o_index.
//       - transition 14 -> 1: pulse o_sweep and increment o_sweep_count.
//     - mismatch:
//       - pulse o_error; o_err_count += 1 unless saturated; o_locked drops.
//       - sample is 8'h01: go to SYNC with o_index=1, count=1.
//       - otherwise: go to HUNT with o_index=0.
//   Ambiguous 8'h02 (index 2 or 14) is resolved only by the expected index and is never decoded standalone.
//   o_dir is derived from the o_index register (0 when o_index=0).
//   Match count width: 8 bits.
// TESTING
//   1. Reset, then one valid sample per cycle of 00,01,02,04,...,80,40,...,02.
//      -> o_locked=1 the cycle after the 8'h02 at index 14; o_index steps 1..14.
//      -> o_dir=1 from index 9.
//   2. Continue the sequence with 01,02,... for 3 sweeps.
//      -> o_sweep pulses on each 01 after 02 (index 14 -> 1); o_sweep_count=3; o_err_count=0.
//   3. While LOCKED, send 8'h08 where 8'h10 is expected.
//      -> o_error pulses for 1 cycle; o_err_count=1; o_locked=0; o_index=0.
//      -> Relock 14 samples after the next 8'h01.
//   4. Repeat test 1 with i_valid=1 one cycle in three, junk on i_led when i_valid=0.
//      -> identical lock and index sequence; outputs hold between valid samples.
//   5. In SYNC, send 8'h03 -> state returns to HUNT, o_error stays 0.
//      Then send 8'h01 with LOCK_COUNT=1 -> o_locked=1 on the next cycle.
//   6. Force 300 LOCKED mismatches (relocking each time) -> o_err_count saturates at 8'hFF.
//      Assert i_reset mid-sweep -> every output is 0 on the next cycle.

Source files
------------

// File: rtl/led_sweep_checker.sv
// led_sweep_checker
//   Receive-side checker for the 8-LED bounce ("knight rider") pattern.
//   Recovers the sweep position (1..14) from a sampled LED bus, locks onto a
//   valid sweep after LOCK_COUNT consecutive matches, flags departures from
//   the sequence while locked and counts completed sweeps.
// Ports:
//   i_clk          system clock, all logic on posedge
//   i_reset        synchronous active-high reset
//   i_valid        qualifies i_led; nothing advances when low
//   i_led          LED bus under test
//   o_locked       high while locked onto the sweep
//   o_index        index of the last matched sample (1..14), 0 while hunting
//   o_dir          0 for indices 1..8 (rising), 1 for 9..14 (falling)
//   o_error        one-cycle pulse on a mismatch while locked
//   o_sweep        one-cycle pulse on a locked 14 -> 1 transition
//   o_err_count    saturating count of o_error pulses
//   o_sweep_count  wrapping count of o_sweep pulses
module led_sweep_checker #(
  parameter int unsigned LOCK_COUNT = 14,
  parameter int unsigned ERR_W      = 8,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_valid,
  input  logic [7:0]       i_led,
  output logic             o_locked,
  output logic [3:0]       o_index,
  output logic             o_dir,
  output logic             o_error,
  output logic             o_sweep,
  output logic [ERR_W-1:0] o_err_count,
  output logic [CNT_W-1:0] o_sweep_count
);

  typedef enum logic [1:0] {
    S_HUNT,
    S_SYNC,
    S_LOCKED
  } state_t;

  localparam logic [7:0] LC = 8'(LOCK_COUNT);

  state_t           r_state;
  logic [3:0]       r_index;
  logic [7:0]       r_match;
  logic             r_locked;
  logic             r_error;
  logic             r_sweep;
  logic [ERR_W-1:0] r_err_count;
  logic [CNT_W-1:0] r_sweep_count;

  state_t     w_state_nxt;
  logic [3:0] w_index_nxt;
  logic [7:0] w_match_nxt;
  logic       w_error_nxt;
  logic       w_sweep_nxt;
  logic [3:0] w_next_idx;
  logic [7:0] w_match_inc;
  logic       w_hit;

  // Pattern expected at a given sweep index; 8'h02 appears at both 2 and 14,
  // so the bus is only ever compared against the pattern of the next index.
  function automatic logic [7:0] f_pattern(input logic [3:0] idx);
    if (idx <= 4'd8) return 8'h01 << (idx - 4'd1);
    else             return 8'h80 >> (idx - 4'd8);
  endfunction

  assign w_next_idx  = (r_index == 4'd14) ? 4'd1 : r_index + 4'd1;
  assign w_match_inc = r_match + 8'd1;
  assign w_hit       = (i_led == f_pattern(w_next_idx));

  always_comb begin
    w_state_nxt = r_state;
    w_index_nxt = r_index;
    w_match_nxt = r_match;
    w_error_nxt = 1'b0;
    w_sweep_nxt = 1'b0;
    if (i_valid) begin
      case (r_state)
        S_HUNT: begin
          if (i_led == 8'h01) begin
            w_index_nxt = 4'd1;
            w_match_nxt = 8'd1;
            w_state_nxt = (LOCK_COUNT == 1) ? S_LOCKED : S_SYNC;
          end else begin
            w_index_nxt = '0;
            w_match_nxt = '0;
          end
        end
        S_SYNC: begin
          if (w_hit) begin
            w_index_nxt = w_next_idx;
            w_match_nxt = w_match_inc;
            if (w_match_inc >= LC) w_state_nxt = S_LOCKED;
          end else if (i_led == 8'h01) begin
            w_index_nxt = 4'd1;
            w_match_nxt = 8'd1;
          end else begin
            w_state_nxt = S_HUNT;
            w_index_nxt = '0;
            w_match_nxt = '0;
          end
        end
        S_LOCKED: begin
          if (w_hit) begin
            w_index_nxt = w_next_idx;
            w_sweep_nxt = (r_index == 4'd14);
          end else begin
            w_error_nxt = 1'b1;
            if (i_led == 8'h01) begin
              w_state_nxt = S_SYNC;
              w_index_nxt = 4'd1;
              w_match_nxt = 8'd1;
            end else begin
              w_state_nxt = S_HUNT;
              w_index_nxt = '0;
              w_match_nxt = '0;
            end
          end
        end
        default: begin
          w_state_nxt = S_HUNT;
          w_index_nxt = '0;
          w_match_nxt = '0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= S_HUNT;
      r_index       <= '0;
      r_match       <= '0;
      r_locked      <= 1'b0;
      r_error       <= 1'b0;
      r_sweep       <= 1'b0;
      r_err_count   <= '0;
      r_sweep_count <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_index  <= w_index_nxt;
      r_match  <= w_match_nxt;
      r_locked <= (w_state_nxt == S_LOCKED);
      r_error  <= w_error_nxt;
      r_sweep  <= w_sweep_nxt;
      if (w_error_nxt && (r_err_count != '1))
        r_err_count <= r_err_count + ERR_W'(1);
      if (w_sweep_nxt)
        r_sweep_count <= r_sweep_count + CNT_W'(1);
    end
  end

  assign o_locked      = r_locked;
  assign o_index       = r_index;
  assign o_dir         = (r_index >= 4'd9);
  assign o_error       = r_error;
  assign o_sweep       = r_sweep;
  assign o_err_count   = r_err_count;
  assign o_sweep_count = r_sweep_count;

endmodule

// File: tb/tb_led_sweep_checker.sv
// Testbench for led_sweep_checker: randomized and directed stimulus compared
// against a table-driven behavioural model of the sweep checker.
module tb_led_sweep_checker;

  logic        clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_valid = 1'b0;
  logic [7:0]  i_led = 8'h00;

  logic        o_locked, o_dir, o_error, o_sweep;
  logic [3:0]  o_index;
  logic [7:0]  o_err_count;
  logic [15:0] o_sweep_count;

  logic        d1_locked, d1_dir, d1_error, d1_sweep;
  logic [3:0]  d1_index;
  logic [7:0]  d1_err_count;
  logic [15:0] d1_sweep_count;

  always #5 clk = ~clk;

  led_sweep_checker #(.LOCK_COUNT(14), .ERR_W(8), .CNT_W(16)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_valid(i_valid), .i_led(i_led),
    .o_locked(o_locked), .o_index(o_index), .o_dir(o_dir),
    .o_error(o_error), .o_sweep(o_sweep),
    .o_err_count(o_err_count), .o_sweep_count(o_sweep_count)
  );

  led_sweep_checker #(.LOCK_COUNT(1), .ERR_W(8), .CNT_W(16)) dut1 (
    .i_clk(clk), .i_reset(i_reset), .i_valid(i_valid), .i_led(i_led),
    .o_locked(d1_locked), .o_index(d1_index), .o_dir(d1_dir),
    .o_error(d1_error), .o_sweep(d1_sweep),
    .o_err_count(d1_err_count), .o_sweep_count(d1_sweep_count)
  );

  // Sweep position -> lit LED, position 0 unused.
  logic [7:0] tbl [0:14] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20,
                             8'h40, 8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02};

  // Reference model: mode 0 = hunting, 1 = synchronising, 2 = locked.
  int          m_mode = 0;
  int          m_idx  = 0;
  int          m_cnt  = 0;
  logic        m_err  = 1'b0;
  logic        m_sweep = 1'b0;
  int          m_ecnt = 0;
  int          m_scnt = 0;

  int n_pass  = 0;
  int n_total = 0;

  logic [31:0] w_act, w_exp;
  assign w_act = {o_locked, o_index, o_dir, o_error, o_sweep, o_err_count, o_sweep_count};
  assign w_exp = {(m_mode == 2), 4'(m_idx), (m_idx >= 9), m_err, m_sweep, 8'(m_ecnt), 16'(m_scnt)};

  function automatic int next_pos(input int p);
    return (p >= 14) ? 1 : p + 1;
  endfunction

  task automatic model_update(input logic rst, input logic v, input logic [7:0] led);
    int nxt;
    m_err   = 1'b0;
    m_sweep = 1'b0;
    if (rst) begin
      m_mode = 0; m_idx = 0; m_cnt = 0; m_ecnt = 0; m_scnt = 0;
    end else if (v) begin
      nxt = next_pos(m_idx);
      if (m_mode == 0) begin
        if (led == 8'h01) begin m_idx = 1; m_cnt = 1; m_mode = 1; end
        else m_idx = 0;
      end else if (led == tbl[nxt]) begin
        if (m_mode == 2 && m_idx == 14) begin
          m_sweep = 1'b1;
          m_scnt  = (m_scnt + 1) % 65536;
        end
        m_idx = nxt;
        if (m_mode == 1) begin
          m_cnt = m_cnt + 1;
          if (m_cnt >= 14) m_mode = 2;
        end
      end else begin
        if (m_mode == 2) begin
          m_err = 1'b1;
          if (m_ecnt < 255) m_ecnt = m_ecnt + 1;
        end
        if (led == 8'h01) begin m_mode = 1; m_idx = 1; m_cnt = 1; end
        else begin m_mode = 0; m_idx = 0; m_cnt = 0; end
      end
    end
  endtask

  task automatic step(input logic rst, input logic v, input logic [7:0] led);
    @(negedge clk);
    i_reset = rst; i_valid = v; i_led = led;
    @(posedge clk);
    model_update(rst, v, led);
    #1;
  endtask

  task automatic test_reset();
    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b1, 8'h01);
    n_total++;
    if (w_act !== 32'h0) $display("FAIL reset_state: got %h expected %h", w_act, 32'h0);
    else n_pass++;
    step(1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_lock();
    for (int i = 0; i <= 14; i++) begin
      step(1'b0, 1'b1, tbl[i]);
      n_total++;
      if (w_act !== w_exp) $display("FAIL lock_seq[%0d]: got %h expected %h", i, w_act, w_exp);
      else n_pass++;
    end
    n_total++;
    if ({o_locked, o_index, o_dir} !== {1'b1, 4'd14, 1'b1})
      $display("FAIL lock_final: got %b expected %b", {o_locked, o_index, o_dir}, 6'b1_1110_1);
    else n_pass++;
  endtask

  task automatic test_sweeps();
    for (int i = 0; i < 42; i++) begin
      step(1'b0, 1'b1, tbl[(i % 14) + 1]);
      n_total++;
      if (w_act !== w_exp) $display("FAIL sweeps[%0d]: got %h expected %h", i, w_act, w_exp);
      else n_pass++;
    end
    n_total++;
    if ({o_sweep_count, o_err_count} !== {16'd3, 8'd0})
      $display("FAIL sweep_count: got %h expected %h", {o_sweep_count, o_err_count}, 24'h000300);
    else n_pass++;
  endtask

  task automatic test_error();
    logic [7:0] seq [0:5] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h08, 8'h00};
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b1, seq[i]);
      n_total++;
      if (w_act !== w_exp) $display("FAIL error_seq[%0d]: got %h expected %h", i, w_act, w_exp);
      else n_pass++;
      if (i == 4) begin
        n_total++;
        if ({o_error, o_err_count, o_locked, o_index} !== {1'b1, 8'd1, 1'b0, 4'd0})
          $display("FAIL error_pulse: got %h expected %h",
                   {o_error, o_err_count, o_locked, o_index}, {1'b1, 8'd1, 1'b0, 4'd0});
        else n_pass++;
      end
    end
    for (int i = 1; i <= 14; i++) begin
      step(1'b0, 1'b1, tbl[i]);
      n_total++;
      if (w_act !== w_exp) $display("FAIL relock[%0d]: got %h expected %h", i, w_act, w_exp);
      else n_pass++;
    end
    n_total++;
    if ({o_locked, o_error} !== 2'b10)
      $display("FAIL relock_final: got %b expected %b", {o_locked, o_error}, 2'b10);
    else n_pass++;
  endtask

  task automatic test_sparse();
    logic [3:0] last_idx;
    step(1'b1, 1'b0, 8'h00);
    for (int i = 0; i <= 14; i++) begin
      for (int k = 0; k < 3; k++) begin
        last_idx = o_index;
        if (k == 0) step(1'b0, 1'b1, tbl[i]);
        else        step(1'b0, 1'b0, 8'($urandom_range(0, 255)));
        n_total++;
        if (w_act !== w_exp) $display("FAIL sparse[%0d.%0d]: got %h expected %h", i, k, w_act, w_exp);
        else n_pass++;
        if (k != 0) begin
          n_total++;
          if (o_index !== last_idx) $display("FAIL sparse_hold[%0d]: got %0d expected %0d", i, o_index, last_idx);
          else n_pass++;
        end
      end
    end
    n_total++;
    if (o_locked !== 1'b1) $display("FAIL sparse_locked: got %b expected 1", o_locked);
    else n_pass++;
  endtask

  task automatic test_sync_bad();
    logic [7:0] seq [0:2] = '{8'h01, 8'h02, 8'h03};
    step(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, seq[i]);
      n_total++;
      if (w_act !== w_exp) $display("FAIL sync_bad[%0d]: got %h expected %h", i, w_act, w_exp);
      else n_pass++;
    end
    n_total++;
    if ({o_error, o_index, o_locked} !== 6'b0)
      $display("FAIL sync_to_hunt: got %b expected 000000", {o_error, o_index, o_locked});
    else n_pass++;
    step(1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'h01);
    n_total++;
    if ({d1_locked, d1_index, d1_error} !== {1'b1, 4'd1, 1'b0})
      $display("FAIL lock_count_one: got %b expected %b", {d1_locked, d1_index, d1_error}, 6'b1_0001_0);
    else n_pass++;
    step(1'b0, 1'b1, 8'h02);
    n_total++;
    if ({d1_locked, d1_index, d1_error} !== {1'b1, 4'd2, 1'b0})
      $display("FAIL lock_count_one_next: got %b expected %b", {d1_locked, d1_index, d1_error}, 6'b1_0010_0);
    else n_pass++;
  endtask

  task automatic test_random();
    logic       v;
    logic [7:0] led;
    step(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 600; i++) begin
      v = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) led = 8'($urandom_range(0, 255));
      else if (m_mode == 0)           led = 8'h01;
      else                            led = tbl[next_pos(m_idx)];
      step(1'b0, v, led);
      n_total++;
      if (w_act !== w_exp) $display("FAIL random[%0d]: got %h expected %h", i, w_act, w_exp);
      else n_pass++;
    end
  endtask

  task automatic test_saturate();
    step(1'b1, 1'b0, 8'h00);
    for (int i = 1; i <= 14; i++) step(1'b0, 1'b1, tbl[i]);
    for (int n = 0; n < 300; n++) begin
      step(1'b0, 1'b1, 8'h01);
      step(1'b0, 1'b1, 8'h02);
      step(1'b0, 1'b1, 8'h01);
      n_total++;
      if (w_act !== w_exp) $display("FAIL saturate_err[%0d]: got %h expected %h", n, w_act, w_exp);
      else n_pass++;
      for (int i = 2; i <= 14; i++) step(1'b0, 1'b1, tbl[i]);
      n_total++;
      if (w_act !== w_exp) $display("FAIL saturate_relock[%0d]: got %h expected %h", n, w_act, w_exp);
      else n_pass++;
    end
    n_total++;
    if (o_err_count !== 8'hFF) $display("FAIL err_saturated: got %h expected ff", o_err_count);
    else n_pass++;
    for (int i = 1; i <= 10; i++) step(1'b0, 1'b1, tbl[i]);
    step(1'b1, 1'b1, tbl[11]);
    n_total++;
    if (w_act !== 32'h0) $display("FAIL reset_mid_sweep: got %h expected %h", w_act, 32'h0);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_lock();
    test_sweeps();
    test_error();
    test_sparse();
    test_sync_bad();
    test_random();
    test_saturate();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
